// File: rtl/axis_mty_to_keep_if.sv
// ---------------------------------------------------------------------------
// axis_mty_to_keep_if
//
// Purpose : One AXI-Stream style beat bus. It is used for both sides of
//           axis_mty_to_keep. The ingress side uses tmty, and the egress
//           side uses tkeep.
//
// Parameters:
//   DWIDTH    - data width in bits (multiple of 8)
//   BYTES     - derived byte-lane count
//   MTY_WIDTH - derived empty-count width
//
// Signals:
//   tdata  - beat data; byte lane BYTES-1 (MSB) carries the first byte
//   tvalid - beat valid (master -> slave)
//   tready - beat accepted when tvalid & tready (slave -> master)
//   tlast  - last beat of packet
//   tmty   - number of empty LSB byte lanes on the last beat
//   tkeep  - per-byte valid mask, MSB-justified
// ---------------------------------------------------------------------------
interface axis_mty_to_keep_if #(
   parameter int DWIDTH = 64
);
   localparam int BYTES     = DWIDTH / 8;
   localparam int MTY_WIDTH = $clog2(BYTES);

   logic [DWIDTH-1:0]    tdata;
   logic                 tvalid;
   logic                 tready;
   logic                 tlast;
   logic [MTY_WIDTH-1:0] tmty;
   logic [BYTES-1:0]     tkeep;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      output tmty,
      output tkeep,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      input  tmty,
      input  tkeep,
      output tready
   );
endinterface

// File: rtl/axis_mty_to_keep.sv
// ---------------------------------------------------------------------------
// axis_mty_to_keep
//
// Purpose : Egress stream converter. It turns an empty-byte count (tmty)
//           carried on the last beat into an MSB-justified AXI-Stream tkeep
//           mask. It is fully registered: an output register (OR) plus one
//           skid register (SK) break both the valid and ready paths. There is
//           no combinational path from s_axis to m_axis.
//
// Parameters:
//   DWIDTH - data width in bits, multiple of 8, 16..512
//
// Ports:
//   clk     - single clock
//   rst_n   - asynchronous active-low reset
//   s_axis  - ingress beats (slave modport); tmty is used, tkeep is ignored
//   m_axis  - egress beats (master modport); tkeep is generated, tmty is 0
//   pkt_cnt - count of last-beat handshakes on m_axis (wraps at 2^32)
//   mty_err - sticky malformed-mty flag (only with MTY_CHECK_EN)
//
// Optional feature macro: MTY_CHECK_EN
//   When it is defined, the module adds the mty_err port. The flag sets on an
//   accepted non-last beat with tmty != 0. It also sets on an accepted last
//   beat with tmty >= BYTES. It stays set until reset.
// ---------------------------------------------------------------------------
module axis_mty_to_keep #(
   parameter int DWIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   axis_mty_to_keep_if.slave         s_axis,
   axis_mty_to_keep_if.master        m_axis,
   output logic [31:0]               pkt_cnt
`ifdef MTY_CHECK_EN
   ,
   output logic                      mty_err
`endif
);
   localparam int BYTES     = DWIDTH / 8;
   localparam int MTY_WIDTH = $clog2(BYTES);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t               state_q;
   logic                 s_ready_q;
   logic                 m_valid_q;
   logic [DWIDTH-1:0]    or_data_q;
   logic [BYTES-1:0]     or_keep_q;
   logic                 or_last_q;
   logic [DWIDTH-1:0]    sk_data_q;
   logic [BYTES-1:0]     sk_keep_q;
   logic                 sk_last_q;
   logic [31:0]          pkt_cnt_q;

   logic                 in_hs;
   logic                 out_hs;
   logic [MTY_WIDTH-1:0] mty_eff;
   logic [BYTES-1:0]     keep_d;

   // Ingress tkeep is not meaningful on this side.
   logic                 unused_s_keep;
   assign unused_s_keep = ^s_axis.tkeep;

   assign in_hs  = s_axis.tvalid & s_ready_q;
   assign out_hs = m_valid_q & m_axis.tready;

   // -----------------------------------------------------------------------
   // mty clamp. When BYTES is a power of two, every tmty code is a legal
   // lane count, so no clamp logic is built. Otherwise, codes >= BYTES are
   // clamped to BYTES-1 so at least one byte stays valid.
   // -----------------------------------------------------------------------
   generate
      if ((1 << MTY_WIDTH) == BYTES) begin : g_mty_pow2
         assign mty_eff = s_axis.tmty;
      end else begin : g_mty_clamp
         assign mty_eff = ({1'b0, s_axis.tmty} >= (MTY_WIDTH + 1)'(BYTES))
                          ? MTY_WIDTH'(BYTES - 1) : s_axis.tmty;
      end
   endgenerate

   // Lane gi is kept on non-last beats, or when it lies at or above the
   // first empty lane count on the last beat.
   generate
      for (genvar gi = 0; gi < BYTES; gi++) begin : g_keep
         assign keep_d[gi] = ~s_axis.tlast |
                             ((MTY_WIDTH + 1)'(gi) >= {1'b0, mty_eff});
      end
   endgenerate

   // -----------------------------------------------------------------------
   // Two-entry buffer FSM. The ready and valid outputs are registered
   // alongside the state, so every transition sets them explicitly.
   // After reset, s_ready_q rises on the first edge: EMPTY is never TWO.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         s_ready_q <= 1'b0;
         m_valid_q <= 1'b0;
         or_data_q <= '0;
         or_keep_q <= '0;
         or_last_q <= 1'b0;
         sk_data_q <= '0;
         sk_keep_q <= '0;
         sk_last_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_EMPTY: begin
               s_ready_q <= 1'b1;
               if (in_hs) begin
                  or_data_q <= s_axis.tdata;
                  or_keep_q <= keep_d;
                  or_last_q <= s_axis.tlast;
                  m_valid_q <= 1'b1;
                  state_q   <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_hs && m_axis.tready) begin
                  or_data_q <= s_axis.tdata;
                  or_keep_q <= keep_d;
                  or_last_q <= s_axis.tlast;
               end else if (in_hs) begin
                  // Downstream stalled: park the new beat in the skid slot.
                  sk_data_q <= s_axis.tdata;
                  sk_keep_q <= keep_d;
                  sk_last_q <= s_axis.tlast;
                  s_ready_q <= 1'b0;
                  state_q   <= ST_TWO;
               end else if (m_axis.tready) begin
                  m_valid_q <= 1'b0;
                  state_q   <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (m_axis.tready) begin
                  or_data_q <= sk_data_q;
                  or_keep_q <= sk_keep_q;
                  or_last_q <= sk_last_q;
                  s_ready_q <= 1'b1;
                  state_q   <= ST_ONE;
               end
            end
            default: begin
               state_q   <= ST_EMPTY;
               s_ready_q <= 1'b0;
               m_valid_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt_q <= '0;
      end else if (out_hs && or_last_q) begin
         pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
   end

`ifdef MTY_CHECK_EN
   logic mty_over;
   logic mty_err_q;

   generate
      if ((1 << MTY_WIDTH) == BYTES) begin : g_over_pow2
         assign mty_over = 1'b0;
      end else begin : g_over_cmp
         assign mty_over = ({1'b0, s_axis.tmty} >= (MTY_WIDTH + 1)'(BYTES));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mty_err_q <= 1'b0;
      end else if (in_hs && ((!s_axis.tlast && (s_axis.tmty != '0)) ||
                             (s_axis.tlast && mty_over))) begin
         mty_err_q <= 1'b1;
      end
   end

   assign mty_err = mty_err_q;
`endif

   assign s_axis.tready = s_ready_q;
   assign m_axis.tvalid = m_valid_q;
   assign m_axis.tdata  = or_data_q;
   assign m_axis.tkeep  = or_keep_q;
   assign m_axis.tlast  = or_last_q;
   assign m_axis.tmty   = '0;
   assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_axis_mty_to_keep.sv
// ---------------------------------------------------------------------------
// tb_axis_mty_to_keep
//
// Directed bench for axis_mty_to_keep (DWIDTH=64). Inputs are driven and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axis_mty_to_keep;
   localparam int DWIDTH = 64;

   logic        clk;
   logic        rst_n;
   logic [31:0] pkt_cnt;
`ifdef MTY_CHECK_EN
   logic        mty_err;
`endif

   int checks   = 0;
   int failures = 0;

   axis_mty_to_keep_if #(.DWIDTH(DWIDTH)) s_if ();
   axis_mty_to_keep_if #(.DWIDTH(DWIDTH)) m_if ();

   axis_mty_to_keep #(.DWIDTH(DWIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_axis  (s_if),
      .m_axis  (m_if),
      .pkt_cnt (pkt_cnt)
`ifdef MTY_CHECK_EN
      ,
      .mty_err (mty_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        last;
      logic [2:0]  mty;
      logic [63:0] data;
      logic [7:0]  keep;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic l, input logic [2:0] m);
      s_if.tvalid = v;
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tmty   = m;
   endtask

   task automatic check_out(input string name, input logic [63:0] d, input logic [7:0] k, input logic l);
      check({name, "_valid"}, 64'(m_if.tvalid), 64'd1);
      check({name, "_data"},  m_if.tdata, d);
      check({name, "_keep"},  64'(m_if.tkeep), 64'(k));
      check({name, "_last"},  64'(m_if.tlast), 64'(l));
   endtask

   initial begin
      vecs[0] = '{1'b1, 3'd0, 64'h0011_2233_4455_6677, 8'hFF};
      vecs[1] = '{1'b1, 3'd1, 64'h8899_AABB_CCDD_EEFF, 8'hFE};
      vecs[2] = '{1'b1, 3'd3, 64'hDEAD_BEEF_0123_4567, 8'hF8};
      vecs[3] = '{1'b1, 3'd7, 64'hA5A5_5A5A_F0F0_0F0F, 8'h80};
      vecs[4] = '{1'b0, 3'd0, 64'h1357_9BDF_2468_ACE0, 8'hFF};
      vecs[5] = '{1'b1, 3'd5, 64'hCAFE_F00D_BAAD_C0DE, 8'hE0};

      rst_n       = 1'b0;
      s_if.tkeep  = '0;
      m_if.tready = 1'b1;
      drive(1'b0, 64'd0, 1'b0, 3'd0);

      // ---------------- reset / ready ----------------
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rst_s_ready", 64'(s_if.tready), 64'd0);
         check("rst_m_valid", 64'(m_if.tvalid), 64'd0);
         check("rst_m_data",  m_if.tdata, 64'd0);
         check("rst_m_keep",  64'(m_if.tkeep), 64'd0);
         check("rst_m_last",  64'(m_if.tlast), 64'd0);
         check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      end
      rst_n = 1'b1;
      #1;
      check("rel_s_ready_before_edge", 64'(s_if.tready), 64'd0);
      @(negedge clk);
      check("rel_s_ready_after_edge", 64'(s_if.tready), 64'd1);
      check("rel_m_valid", 64'(m_if.tvalid), 64'd0);
      $display("reset: done, s_axis_tready=%0d", s_if.tready);

      // ---------------- keep decode table ----------------
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, vecs[i].data, vecs[i].last, vecs[i].mty);
         @(negedge clk);
         drive(1'b0, 64'd0, 1'b0, 3'd0);
         check_out($sformatf("vec%0d", i), vecs[i].data, vecs[i].keep, vecs[i].last);
         $display("vec%0d: last=%0d mty=%0d keep=%02h", i, vecs[i].last, vecs[i].mty, m_if.tkeep);
      end
      @(negedge clk);
      check("vec_drained", 64'(m_if.tvalid), 64'd0);
      check("vec_pkt_cnt", 64'(pkt_cnt), 64'd5);

      // ---------------- backpressure ----------------
      m_if.tready = 1'b0;
      drive(1'b1, 64'hB1, 1'b0, 3'd0);
      @(negedge clk);
      check("bp_ready_one", 64'(s_if.tready), 64'd1);
      drive(1'b1, 64'hB2, 1'b0, 3'd0);
      @(negedge clk);
      drive(1'b1, 64'hB3, 1'b1, 3'd2);
      check("bp_ready_two", 64'(s_if.tready), 64'd0);
      check_out("bp_hold1", 64'hB1, 8'hFF, 1'b0);
      @(negedge clk);
      check("bp_ready_two_hold", 64'(s_if.tready), 64'd0);
      check_out("bp_hold2", 64'hB1, 8'hFF, 1'b0);
      $display("backpressure: holding beat %0h, s_axis_tready=%0d", m_if.tdata, s_if.tready);
      m_if.tready = 1'b1;
      @(negedge clk);
      check_out("bp_beat2", 64'hB2, 8'hFF, 1'b0);
      check("bp_ready_reopen", 64'(s_if.tready), 64'd1);
      @(negedge clk);
      drive(1'b0, 64'd0, 1'b0, 3'd0);
      check_out("bp_beat3", 64'hB3, 8'hFC, 1'b1);
      @(negedge clk);
      check("bp_drained", 64'(m_if.tvalid), 64'd0);
      check("bp_pkt_cnt", 64'(pkt_cnt), 64'd6);
      $display("backpressure: beats B1,B2,B3 emitted in order");

      // ---------------- throughput: 100 beats, 10 packets ----------------
      for (int i = 0; i <= 100; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check($sformatf("tp_beat%0d", i - 1), {m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata[53:0]},
                  {1'b1, 1'b1 && ((i - 1) % 10 == 9), 8'hFF, 54'(i - 1)});
         end
         if (i < 100) begin
            check($sformatf("tp_ready%0d", i), 64'(s_if.tready), 64'd1);
            drive(1'b1, 64'(i), (i % 10) == 9, 3'd0);
         end else begin
            drive(1'b0, 64'd0, 1'b0, 3'd0);
         end
      end
      @(negedge clk);
      check("tp_drained", 64'(m_if.tvalid), 64'd0);
      check("tp_pkt_cnt", 64'(pkt_cnt), 64'd16);
      $display("throughput: 100 beats in 101 cycles, pkt_cnt=%0d", pkt_cnt);

      // ---------------- pkt_cnt wrap ----------------
      dut.pkt_cnt_q = 32'hFFFF_FFFF;
      #1;
      check("wrap_preset", 64'(pkt_cnt), 64'hFFFF_FFFF);
      drive(1'b1, 64'h77, 1'b1, 3'd0);
      @(negedge clk);
      drive(1'b0, 64'd0, 1'b0, 3'd0);
      @(negedge clk);
      check("wrap_pkt_cnt", 64'(pkt_cnt), 64'd0);
      $display("wrap: pkt_cnt=%0d", pkt_cnt);

      // ---------------- reset mid-packet ----------------
      m_if.tready = 1'b0;
      drive(1'b1, 64'hC1, 1'b0, 3'd0);
      @(negedge clk);
      drive(1'b1, 64'hC2, 1'b0, 3'd0);
      @(negedge clk);
      drive(1'b0, 64'd0, 1'b0, 3'd0);
      check("mid_two_ready", 64'(s_if.tready), 64'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(m_if.tvalid), 64'd0);
      check("mid_rst_ready", 64'(s_if.tready), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n       = 1'b1;
      m_if.tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("mid_no_beat%0d", i), 64'(m_if.tvalid), 64'd0);
      end
      check("mid_pkt_cnt", 64'(pkt_cnt), 64'd0);
      $display("mid-packet reset: buffered beats discarded");

      // ---------------- malformed mty on non-last beat ----------------
`ifdef MTY_CHECK_EN
      check("err_clear", 64'(mty_err), 64'd0);
`endif
      drive(1'b1, 64'hE1, 1'b0, 3'd2);
      @(negedge clk);
      drive(1'b0, 64'd0, 1'b0, 3'd0);
      check_out("err_beat", 64'hE1, 8'hFF, 1'b0);
`ifdef MTY_CHECK_EN
      check("err_set", 64'(mty_err), 64'd1);
`endif
      drive(1'b1, 64'hE2, 1'b1, 3'd0);
      @(negedge clk);
      drive(1'b0, 64'd0, 1'b0, 3'd0);
      check_out("err_next_pkt", 64'hE2, 8'hFF, 1'b1);
      @(negedge clk);
`ifdef MTY_CHECK_EN
      check("err_sticky", 64'(mty_err), 64'd1);
      rst_n = 1'b0;
      #1;
      check("err_cleared_by_reset", 64'(mty_err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
`endif
      $display("mty check: non-last mty=2 forwarded with keep=ff");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/axis_mty_to_keep.md
Name: axis_mty_to_keep

Overview:
- Stream converter: accepts a beat stream carrying an empty-byte count (mty) on the last beat and emits AXI-Stream with a per-byte tkeep mask.
- Inverse of the keep-to-mty leading-ones counter used on the receive path; sits at the egress of the RIFL framing datapath toward AXI-Stream user logic.
- Fully registered; a 2-entry skid buffer breaks both the valid and ready timing paths.

Parameters:
- DWIDTH, 64, data width in bits; must be a multiple of 8, range 16..512.
- BYTES, DWIDTH/8, derived byte-lane count; do not override.
- MTY_WIDTH, $clog2(BYTES), derived mty width; do not override.

Ports:
- clk  input  1  single clock for all logic
- rst_n  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- s_axis_tdata  input  DWIDTH  input data; byte lane BYTES-1 (MSB) carries the first byte
- s_axis_tvalid  input  1  input beat valid
- s_axis_tready  output  1  input beat accepted when tvalid & tready
- s_axis_tlast  input  1  last beat of packet
- s_axis_tmty  input  MTY_WIDTH  number of empty LSB byte lanes; meaningful only when tlast=1
- m_axis_tdata  output  DWIDTH  output data, unchanged from input
- m_axis_tkeep  output  BYTES  byte-valid mask, MSB-justified
- m_axis_tvalid  output  1  output beat valid
- m_axis_tready  input  1  downstream ready
- m_axis_tlast  output  1  last beat of packet
- pkt_cnt  output  32  packets emitted (count of last-beat handshakes on m_axis)
- mty_err  output  1  sticky mty error flag; present only with MTY_CHECK_EN

Behaviour:
- Reset (rst_n=0, asynchronous):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
  - s_axis_tready=0; skid entry empty; pkt_cnt=0; mty_err=0.
- First clk edge after rst_n deasserts: s_axis_tready rises to 1. This uses a registered ready-enable flop so that ready is never high during reset.
- Keep generation:
  - tlast=0: tkeep = all ones; tmty is ignored.
  - tlast=1: tkeep[BYTES-1 : mty] = 1 and tkeep[mty-1 : 0] = 0. mty=0 gives all ones.
  - If mty >= BYTES (possible only when BYTES is not a power of two), mty is clamped to BYTES-1, so at least one byte stays valid.
- Keep is computed on the input side and stored with data and last. There is no combinational path from s_axis to m_axis.
- Latency: 1 cycle from input handshake to m_axis_tvalid when the output register is empty or draining.
- Storage: output register (OR) plus skid register (SK).
  - States: EMPTY (OR invalid), ONE (OR valid, SK empty), TWO (OR and SK valid).
  - s_axis_tready = registered (state != TWO).
  - EMPTY + input handshake -> ONE; input loads OR.
  - ONE + input handshake + m_axis_tready -> ONE; input loads OR.
  - ONE + input handshake + ~m_axis_tready -> TWO; input loads SK.
  - ONE + ~input handshake + m_axis_tready -> EMPTY.
  - TWO + m_axis_tready -> ONE; SK moves to OR. No input is accepted because ready=0.
  - TWO + ~m_axis_tready -> TWO; hold.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable.
- pkt_cnt increments by 1 on each m_axis handshake with tlast=1 and wraps from 2^32-1 to 0.
- Reset asserted mid-packet: all buffered beats are discarded, state returns to EMPTY, and no partial-packet recovery is attempted.
- Full throughput: one beat per cycle is sustained while m_axis_tready is continuously 1.

Optional Feature:
- Macro: MTY_CHECK_EN.
- Defined:
  - mty_err port exists.
  - It sets, and stays set until reset, on an input handshake with tlast=0 and tmty!=0.
  - It also sets on an input handshake with tlast=1 and tmty>=BYTES.
  - Data is still forwarded using the normal clamping rules.
- Undefined: port mty_err and its logic are absent; the module must elaborate without it.

Test Plan:
- Reset/ready: hold rst_n=0 for 5 cycles, then release -> s_axis_tready=0 during reset, 1 on the first edge after; all m_axis outputs and pkt_cnt=0.
- Keep decode (DWIDTH=64): single-beat packets with tlast=1 and mty=0,1,3,7 -> tkeep=0xFF,0xFE,0xF8,0x80; tdata equal to input; pkt_cnt ends at 4.
- Backpressure:
  - Stream 3 beats with m_axis_tready=0 -> after 2 accepted beats, s_axis_tready=0 (state TWO) and outputs stay stable.
  - Raise ready -> beats 1,2,3 emerge in order with no loss.
- Throughput: 100 back-to-back beats, 10 packets of 10 beats each, ready held at 1 -> 100 output beats in 101 cycles; non-last tkeep=0xFF; pkt_cnt=10.
- Wrap/reset: force pkt_cnt to 0xFFFFFFFF and send 1 packet -> pkt_cnt=0. Assert rst_n mid-packet with 2 beats buffered -> m_axis_tvalid=0 immediately and no beats are emitted after release.
- MTY_CHECK_EN: send a non-last beat with mty=2 -> mty_err=1 the next cycle, stays 1 across later packets, and clears only on reset. Without the macro, the same stimulus forwards tkeep=0xFF.
